// File: rtl/text_pkg.sv
// Shared text-mode constants and the character RAM address packing helper
// used by both the renderer and the text writers.
package text_pkg;
  localparam int CELL_W      = 8;
  localparam int CELL_H      = 16;
  localparam int ADDR_W      = 11;
  localparam int FONT_ADDR_W = 12;
  localparam int LIN_W       = 5;
  localparam int COL_W       = 6;
  localparam logic [7:0] BLANK_CODE = 8'h20;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [LIN_W-1:0] lin,
                                                  input logic [COL_W-1:0] col);
    return {lin, col};
  endfunction
endpackage

// File: rtl/text_blink.sv
// Cursor blink phase: counts frame strobes and toggles o_blink_on every
// BLINK_FRAMES frames.
module text_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_frame,
  output logic o_blink_on
);
  localparam logic [5:0] LAST_CNT = 6'(BLINK_FRAMES - 1);

  logic       r_armed;
  logic [5:0] r_frame_cnt;
  logic       r_blink_on;

  // r_armed stays low through the reset-release edge so a strobe there is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_armed     <= 1'b0;
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (i_frame && r_armed) begin
        if (r_frame_cnt == LAST_CNT) begin
          r_frame_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_frame_cnt <= r_frame_cnt + 6'd1;
        end
      end
    end
  end

  assign o_blink_on = r_blink_on;
endmodule

// File: rtl/text_render.sv
// Text-mode renderer: raster position -> character RAM -> font ROM -> pixel,
// three registered stages with sync/active carried alongside.
module text_render
  import text_pkg::*;
#(
  parameter int COLS         = 60,
  parameter int LINES        = 17,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [9:0]             i_x,
  input  logic [9:0]             i_y,
  input  logic                   i_active,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_frame,
  input  logic                   i_cursor_en,
  input  logic [5:0]             i_cursor_col,
  input  logic [4:0]             i_cursor_lin,
  output logic [ADDR_W-1:0]      o_char_addr,
  input  logic [7:0]             i_char_data,
  output logic [FONT_ADDR_W-1:0] o_font_addr,
  input  logic [7:0]             i_font_data,
  output logic                   o_pixel,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_active
);
  localparam int BIT_W = $clog2(CELL_W);
  localparam int ROW_W = $clog2(CELL_H);
  localparam logic [ROW_W-1:0] UL_ROW = ROW_W'(CELL_H - 2);

  if (COLS < 1 || COLS > 64) begin : g_cols_check
    $error("text_render: COLS must be in 1..64");
  end
  if (LINES < 1 || LINES > 32) begin : g_lines_check
    $error("text_render: LINES must be in 1..32");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 63) begin : g_blink_check
    $error("text_render: BLINK_FRAMES must be in 1..63");
  end

  // Free-running stream: one pixel accepted and one produced every cycle, no stalls.
  logic [9-BIT_W:0]      w_col;
  logic [9-ROW_W:0]      w_lin;
  logic                  w_in_text;
  logic                  w_cursor_hit;
  logic [7:0]            w_code;
  logic                  w_blink_on;
  logic                  w_glyph_bit;
  logic                  w_px;

  assign w_col     = i_x[9:BIT_W];
  assign w_lin     = i_y[9:ROW_W];
  assign w_in_text = i_active && (w_col < (10-BIT_W)'(COLS)) && (w_lin < (10-ROW_W)'(LINES));
  assign w_cursor_hit = i_cursor_en && w_in_text &&
                        (w_col == (10-BIT_W)'(i_cursor_col)) &&
                        (w_lin == (10-ROW_W)'(i_cursor_lin));

  // S0 registers
  logic [ADDR_W-1:0] r_char_addr;
  logic [ROW_W-1:0]  r_row0;
  logic [BIT_W-1:0]  r_bit0;
  logic              r_in0;
  logic              r_cur0;
  logic [2:0]        r_side0;
  // S1 registers
  logic [FONT_ADDR_W-1:0] r_font_addr;
  logic [ROW_W-1:0]       r_row1;
  logic [BIT_W-1:0]       r_bit1;
  logic                   r_in1;
  logic                   r_cur1;
  logic [2:0]             r_side1;
  // S2 registers
  logic       r_pixel;
  logic [2:0] r_side2;

  // Control codes have no glyphs of their own; they render as a space.
  assign w_code      = (i_char_data < BLANK_CODE) ? BLANK_CODE : i_char_data;
  assign w_glyph_bit = i_font_data[3'd7 - r_bit1];
  assign w_px        = (r_in1 & w_glyph_bit) ^ (r_cur1 & w_blink_on & (r_row1 >= UL_ROW));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_char_addr <= '0;
      r_row0      <= '0;
      r_bit0      <= '0;
      r_in0       <= 1'b0;
      r_cur0      <= 1'b0;
      r_side0     <= '0;
      r_font_addr <= '0;
      r_row1      <= '0;
      r_bit1      <= '0;
      r_in1       <= 1'b0;
      r_cur1      <= 1'b0;
      r_side1     <= '0;
      r_pixel     <= 1'b0;
      r_side2     <= '0;
    end else begin
      if (w_in_text) begin
        r_char_addr <= pack_addr(w_lin[LIN_W-1:0], w_col[COL_W-1:0]);
      end
      r_row0  <= i_y[ROW_W-1:0];
      r_bit0  <= i_x[BIT_W-1:0];
      r_in0   <= w_in_text;
      r_cur0  <= w_cursor_hit;
      r_side0 <= {i_hsync, i_vsync, i_active};

      r_font_addr <= {w_code, r_row0};
      r_row1      <= r_row0;
      r_bit1      <= r_bit0;
      r_in1       <= r_in0;
      r_cur1      <= r_cur0;
      r_side1     <= r_side0;

      r_pixel <= w_px & r_side1[0];
      r_side2 <= r_side1;
    end
  end

  text_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_frame    (i_frame),
    .o_blink_on (w_blink_on)
  );

  assign o_char_addr = r_char_addr;
  assign o_font_addr = r_font_addr;
  assign o_pixel     = r_pixel;
  assign o_hsync     = r_side2[2];
  assign o_vsync     = r_side2[1];
  assign o_active    = r_side2[0];
endmodule

// File: tb/tb_text_render.sv
// Bench for text_render: memory models, a per-pixel reference model feeding an
// expected queue, and a monitor comparing every output pixel.
module tb_text_render;
  localparam int COLS  = 60;
  localparam int LINES = 17;
  localparam int BF    = 2;
  localparam int W     = 27;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  i_x = '0;
  logic [9:0]  i_y = '0;
  logic        i_active = 1'b0;
  logic        i_hsync = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_frame = 1'b0;
  logic        i_cursor_en = 1'b0;
  logic [5:0]  i_cursor_col = '0;
  logic [4:0]  i_cursor_lin = '0;
  logic [10:0] o_char_addr;
  logic [7:0]  i_char_data;
  logic [11:0] o_font_addr;
  logic [7:0]  i_font_data;
  logic        o_pixel, o_hsync, o_vsync, o_active;

  logic [7:0] ram  [2048];
  logic [7:0] font [4096];

  // Both memories present data on the cycle after the registered address.
  assign i_char_data = ram[o_char_addr];
  assign i_font_data = font[o_font_addr];

  text_render #(.COLS(COLS), .LINES(LINES), .BLINK_FRAMES(BF)) dut (
    .i_clk(clk), .i_rst(rst), .i_x(i_x), .i_y(i_y), .i_active(i_active),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_frame(i_frame),
    .i_cursor_en(i_cursor_en), .i_cursor_col(i_cursor_col), .i_cursor_lin(i_cursor_lin),
    .o_char_addr(o_char_addr), .i_char_data(i_char_data),
    .o_font_addr(o_font_addr), .i_font_data(i_font_data),
    .o_pixel(o_pixel), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_active(o_active)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_smp    = 0;
  bit release_pending = 1'b0;
  bit draining = 1'b0;

  always @(posedge clk) begin
    if (rst) n_smp <= 0;
    else if (n_smp < 1000000) n_smp <= n_smp + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int          m_cnt = 0;
  bit          m_blink = 1'b0;
  bit          m_first = 1'b1;
  logic [10:0] m_last_addr = '0;

  task automatic step(input int x, input int y, input bit act, input bit hs,
                      input bit vs, input bit fr);
    int col, lin, row, b;
    bit in_t, hit, px;
    logic [10:0] addr;
    logic [7:0]  code, g;
    logic [11:0] fa;
    @(posedge clk); #1;
    if (release_pending) begin
      rst = 1'b0;
      release_pending = 1'b0;
    end
    i_x = 10'(x); i_y = 10'(y); i_active = act;
    i_hsync = hs; i_vsync = vs; i_frame = fr;
    col = x / 8; lin = y / 16; row = y % 16; b = x % 8;
    in_t = act && (col < COLS) && (lin < LINES);
    addr = in_t ? 11'(lin * 64 + col) : m_last_addr;
    m_last_addr = addr;
    code = ram[addr];
    if (code < 8'h20) code = 8'h20;
    fa = {code, 4'(row)};
    g  = font[fa];
    px = in_t ? g[7 - b] : 1'b0;
    hit = i_cursor_en && in_t && (col == int'(i_cursor_col)) && (lin == int'(i_cursor_lin));
    if (hit && m_blink && row >= 14) px = !px;
    px = px & act;
    exp_q.push_back({addr, fa, px, hs, vs, act});
    if (fr) begin
      if (m_first) ;
      else if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_blink = !m_blink;
      end else m_cnt++;
    end
    m_first = 1'b0;
  endtask

  task automatic do_frame();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic scan_cell(input int cx, input int cy);
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < 8; b++)
        step(cx * 8 + b, cy * 16 + r, 1, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_char_addr", 32'(o_char_addr), 0);
    chk("rst_font_addr", 32'(o_font_addr), 0);
    chk("rst_pixel",     32'(o_pixel), 0);
    chk("rst_hsync",     32'(o_hsync), 0);
    chk("rst_vsync",     32'(o_vsync), 0);
    chk("rst_active",    32'(o_active), 0);
    i_frame = 1'b1;
    repeat (3) @(posedge clk);
    m_cnt = 0; m_blink = 1'b0; m_first = 1'b1; m_last_addr = '0;
    release_pending = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [10:0]  ca_d1 = '0, ca_d2 = '0;
  logic [11:0]  fa_d1 = '0;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (!rst && n_smp >= 3) begin
      if (exp_q.size() == 0) begin
        if (!draining) chk("queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("char_addr", 32'(ca_d2), 32'(e[26:16]));
        chk("font_addr", 32'(fa_d1), 32'(e[15:4]));
        chk("pixel",     32'(o_pixel), 32'(e[3]));
        chk("sync",      32'({o_hsync, o_vsync, o_active}), 32'(e[2:0]));
      end
    end
    ca_d2 = ca_d1;
    ca_d1 = o_char_addr;
    fa_d1 = o_font_addr;
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4096; i++) font[i] = 8'($urandom_range(1, 255));
    for (int r = 0; r < 16; r++) font[12'h200 + r] = 8'h00;
    ram[11'h083] = 8'h41;
    font[12'h415] = 8'b0001_1000;
    ram[11'h085] = 8'h0A;

    @(negedge clk);
    chk("init_char_addr", 32'(o_char_addr), 0);
    chk("init_pixel", 32'(o_pixel), 0);
    chk("init_active", 32'(o_active), 0);
    repeat (2) @(posedge clk);
    release_pending = 1'b1;

    // Glyph 'A' at cell (3,2), row 5: bit 3 on, bit 0 off.
    step(27, 37, 1, 0, 0, 0);
    step(24, 37, 1, 0, 0, 0);
    // Outside the text area: address holds, pixel off, active passes.
    step(480, 37, 1, 1, 0, 0);
    step(27, 272, 1, 0, 1, 0);
    step(1000, 900, 1, 1, 1, 0);
    step(27, 37, 0, 0, 0, 0);
    // Control code at cell (5,2) renders from the blank glyph.
    for (int r = 0; r < 16; r += 5)
      for (int b = 0; b < 8; b++) step(40 + b, 32 + r, 1, 0, 0, 0);

    // Random raster, sync and cursor segments.
    for (int s = 0; s < 5; s++) begin
      i_cursor_en  = 1'($urandom_range(0, 1));
      i_cursor_col = 6'($urandom_range(0, 63));
      i_cursor_lin = 5'($urandom_range(0, 31));
      for (int k = 0; k < 120; k++) begin
        if (k % 40 == 0 && i_cursor_en) begin
          step(int'(i_cursor_col) * 8 + $urandom_range(0, 7),
               int'(i_cursor_lin) * 16 + $urandom_range(12, 15), 1, 0, 0, 0);
        end else begin
          step($urandom_range(0, 1023), $urandom_range(0, 520),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 0);
        end
      end
      do_frame();
    end

    // Mid-line reset, then cursor blink from a known phase.
    step(300, 100, 1, 0, 0, 0);
    apply_reset();
    ram[11'h083] = 8'h00;
    i_cursor_en = 1'b1; i_cursor_col = 6'd3; i_cursor_lin = 5'd2;
    step(0, 0, 0, 0, 0, 1);
    scan_cell(3, 2);
    do_frame();
    do_frame();
    scan_cell(3, 2);
    scan_cell(4, 2);
    do_frame();
    scan_cell(3, 2);
    do_frame();
    scan_cell(3, 2);
    i_cursor_col = 6'd62;
    do_frame();
    do_frame();
    for (int b = 0; b < 8; b++) step(496 + b, 46, 1, 0, 0, 0);

    draining = 1'b1;
    repeat (6) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
